// File: rtl/riscv_bp_pkg.sv
// rtl/riscv_bp_pkg.sv - shared branch-prediction types and constants
package riscv_bp_pkg;

  localparam int PC_W_DEFAULT  = 20;
  localparam int CNT_W_DEFAULT = 32;
  localparam int PC_INC        = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  // Two-bit saturating predictor state; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    BP_STRONG_NT = 2'b00,
    BP_WEAK_NT   = 2'b01,
    BP_WEAK_T    = 2'b10,
    BP_STRONG_T  = 2'b11
  } bp_ctr_e;

  localparam int BP_TAKEN_BIT = 1;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - prediction-table update bus
interface branch_resolve_unit_if #(
  parameter int PC_W = 20
);
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_take;
  logic            upd_branch;
  logic            upd_jump;

  modport master (output upd_valid, upd_pc, upd_take, upd_branch, upd_jump);
  modport slave  (input  upd_valid, upd_pc, upd_take, upd_branch, upd_jump);
endinterface

// File: rtl/bp_pred_pipe.sv
// rtl/bp_pred_pipe.sv - F->D->E sideband pipeline with stall and flush
module bp_pred_pipe #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_D,
  input  logic         stall_E,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         e_valid,
  output logic [W-1:0] e_data
);

  logic         d_valid;
  logic [W-1:0] d_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_data  <= '0;
      e_valid <= 1'b0;
      e_data  <= '0;
    end else begin
      if (!stall_D) begin
        d_valid <= in_valid;
        d_data  <= in_data;
      end
      // A stalled D feeding a running E inserts a bubble.
      if (!stall_E) begin
        if (!stall_D) begin
          e_valid <= d_valid;
          e_data  <= d_data;
        end else begin
          e_valid <= 1'b0;
        end
      end
      if (flush) begin
        d_valid <= 1'b0;
        e_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution and predictor update
module branch_resolve_unit
  import riscv_bp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid_F,
  input  logic             pred_taken_F,
  input  logic [PC_W-1:0]  pred_target_F,
  input  logic             stall_D,
  input  logic             stall_E,
  input  logic             branch_E,
  input  logic             jump_E,
  input  logic             take_E,
  input  logic [PC_W-1:0]  pc_E,
  input  logic [PC_W-1:0]  target_E,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_FD,
  branch_resolve_unit_if.master upd,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_mispredict
);

  bru_state_e      state_q, state_d;
  logic [PC_W-1:0] rpc_q;
  logic            pe_valid;
  logic [PC_W:0]   pe_data;
  logic            pe_taken;
  logic [PC_W-1:0] pe_target;
  logic            res, act_taken, mis;
  logic [PC_W-1:0] act_next;

  bp_pred_pipe #(.W(PC_W + 1)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .stall_D  (stall_D),
    .stall_E  (stall_E),
    .flush    (flush_FD),
    .in_valid (fetch_valid_F),
    .in_data  ({pred_taken_F, pred_target_F}),
    .e_valid  (pe_valid),
    .e_data   (pe_data)
  );

  assign pe_taken  = pe_data[PC_W];
  assign pe_target = pe_data[PC_W-1:0];

  // Instructions in E during RECOVER are wrong-path and never resolve.
  assign res       = pe_valid & (branch_E | jump_E) & ~stall_E & (state_q == IDLE);
  assign act_taken = jump_E | take_E;
  assign act_next  = act_taken ? target_E : pc_E + PC_W'(PC_INC);
  assign mis       = res & ((act_taken != pe_taken) |
                            (act_taken & (target_E != pe_target)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    redirect = 1'b0;
    flush_FD = 1'b0;
    case (state_q)
      IDLE:    if (mis) state_d = RECOVER;
      RECOVER: begin
        redirect = 1'b1;
        flush_FD = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign redirect_pc = rpc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpc_q          <= '0;
      upd.upd_valid  <= 1'b0;
      upd.upd_pc     <= '0;
      upd.upd_take   <= 1'b0;
      upd.upd_branch <= 1'b0;
      upd.upd_jump   <= 1'b0;
      cnt_resolved   <= '0;
      cnt_mispredict <= '0;
    end else begin
      upd.upd_valid <= res;
      if (res) begin
        upd.upd_pc     <= pc_E;
        upd.upd_take   <= act_taken;
        upd.upd_branch <= branch_E & ~jump_E;
        upd.upd_jump   <= jump_E;
      end
      if (mis) rpc_q <= act_next;
      if (res && cnt_resolved != {CNT_W{1'b1}})   cnt_resolved   <= cnt_resolved + 1'b1;
      if (mis && cnt_mispredict != {CNT_W{1'b1}}) cnt_mispredict <= cnt_mispredict + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int PC_W  = 20;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             fetch_valid_F = 1'b0;
  logic             pred_taken_F = 1'b0;
  logic [PC_W-1:0]  pred_target_F = '0;
  logic             stall_D = 1'b0;
  logic             stall_E = 1'b0;
  logic             branch_E = 1'b0;
  logic             jump_E = 1'b0;
  logic             take_E = 1'b0;
  logic [PC_W-1:0]  pc_E = '0;
  logic [PC_W-1:0]  target_E = '0;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_FD;
  logic [CNT_W-1:0] cnt_resolved;
  logic [CNT_W-1:0] cnt_mispredict;

  branch_resolve_unit_if #(.PC_W(PC_W)) upd_if ();

  branch_resolve_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid_F  (fetch_valid_F),
    .pred_taken_F   (pred_taken_F),
    .pred_target_F  (pred_target_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .branch_E       (branch_E),
    .jump_E         (jump_E),
    .take_E         (take_E),
    .pc_E           (pc_E),
    .target_E       (target_E),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_FD       (flush_FD),
    .upd            (upd_if),
    .cnt_resolved   (cnt_resolved),
    .cnt_mispredict (cnt_mispredict)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one slot per pipeline stage plus a pending-redirect flag.
  typedef struct {
    bit              v;
    bit              t;
    logic [PC_W-1:0] tg;
  } slot_t;

  slot_t           md, me;
  bit              m_recover;
  logic [PC_W-1:0] m_rpc;
  bit              m_uv, m_ut, m_ub, m_uj;
  logic [PC_W-1:0] m_upc;
  int              m_cres, m_cmis;

  task automatic model_step();
    bit              res, act, mis;
    logic [PC_W-1:0] nxt;
    slot_t           md_n, me_n;
    if (rst) begin
      md = '{1'b0, 1'b0, '0}; me = '{1'b0, 1'b0, '0};
      m_recover = 0; m_rpc = '0; m_uv = 0; m_ut = 0; m_ub = 0; m_uj = 0;
      m_upc = '0; m_cres = 0; m_cmis = 0;
      return;
    end
    res = me.v && (branch_E || jump_E) && !stall_E && !m_recover;
    act = jump_E || take_E;
    nxt = act ? target_E : PC_W'((int'(pc_E) + 4) % (1 << PC_W));
    mis = res && ((act != me.t) || (act && target_E != me.tg));
    md_n = stall_D ? md : '{fetch_valid_F, pred_taken_F, pred_target_F};
    me_n = me;
    if (!stall_E) me_n = stall_D ? '{1'b0, me.t, me.tg} : md;
    if (m_recover) begin md_n.v = 0; me_n.v = 0; end
    m_uv = res;
    if (res) begin
      m_upc = pc_E; m_ut = act; m_ub = branch_E && !jump_E; m_uj = jump_E;
      if (m_cres < CMAX) m_cres++;
    end
    if (mis) begin
      m_rpc = nxt;
      if (m_cmis < CMAX) m_cmis++;
    end
    m_recover = mis;
    md = md_n;
    me = me_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_valid_F = 0; pred_taken_F = 0; pred_target_F = '0;
    stall_D = 0; stall_E = 0; branch_E = 0; jump_E = 0; take_E = 0;
    pc_E = '0; target_E = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic put_pred(input bit t, input logic [PC_W-1:0] tg);
    branch_E = 0; jump_E = 0;
    fetch_valid_F = 1; pred_taken_F = t; pred_target_F = tg;
    tick();
    fetch_valid_F = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; tick(); tick(); rst = 0;
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %0b want 0", redirect); end
    n_checks++; if (flush_FD !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b want 0", flush_FD); end
    n_checks++; if (redirect_pc !== '0) begin n_fail++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
    n_checks++; if (upd_if.upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %0b want 0", upd_if.upd_valid); end
    n_checks++; if (cnt_resolved !== '0 || cnt_mispredict !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_resolved, cnt_mispredict); end
  endtask

  task automatic test_correct_taken();
    do_reset();
    put_pred(1, 20'h00100);
    branch_E = 1; take_E = 1; target_E = 20'h00100; pc_E = 20'h00080;
    tick();
    n_checks++; if (upd_if.upd_valid !== 1'b1 || upd_if.upd_take !== 1'b1) begin n_fail++; $display("FAIL hit_upd: got v=%0b t=%0b want 1 1", upd_if.upd_valid, upd_if.upd_take); end
    n_checks++; if (upd_if.upd_pc !== 20'h00080) begin n_fail++; $display("FAIL hit_upd_pc: got %h want 00080", upd_if.upd_pc); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL hit_redirect: got %0b want 0", redirect); end
    n_checks++; if (cnt_resolved !== 4'd1 || cnt_mispredict !== 4'd0) begin n_fail++; $display("FAIL hit_counters: got %0d/%0d want 1/0", cnt_resolved, cnt_mispredict); end
    branch_E = 0;
    tick();
    n_checks++; if (upd_if.upd_valid !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL hit_one_cycle: got v=%0b r=%0b want 0 0", upd_if.upd_valid, redirect); end
  endtask

  task automatic test_direction_mispredict();
    do_reset();
    branch_E = 0; jump_E = 0;
    fetch_valid_F = 1; pred_taken_F = 0; pred_target_F = 20'h00000;
    tick();
    pred_taken_F = 1; pred_target_F = 20'h00999;
    tick();
    fetch_valid_F = 0;
    branch_E = 1; take_E = 1; pc_E = 20'h00040; target_E = 20'h00200;
    tick();
    n_checks++; if (redirect !== 1'b1 || flush_FD !== 1'b1) begin n_fail++; $display("FAIL dir_redirect: got r=%0b f=%0b want 1 1", redirect, flush_FD); end
    n_checks++; if (redirect_pc !== 20'h00200) begin n_fail++; $display("FAIL dir_rpc: got %h want 00200", redirect_pc); end
    n_checks++; if (cnt_mispredict !== 4'd1 || cnt_resolved !== 4'd1) begin n_fail++; $display("FAIL dir_counters: got %0d/%0d want 1/1", cnt_resolved, cnt_mispredict); end
    tick();
    n_checks++; if (upd_if.upd_valid !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL dir_recover_wrongpath: got v=%0b r=%0b want 0 0", upd_if.upd_valid, redirect); end
    n_checks++; if (cnt_resolved !== 4'd1 || cnt_mispredict !== 4'd1) begin n_fail++; $display("FAIL dir_recover_counts: got %0d/%0d want 1/1", cnt_resolved, cnt_mispredict); end
    branch_E = 0;
    tick();
  endtask

  task automatic test_wrap_not_taken();
    do_reset();
    put_pred(1, 20'h00123);
    branch_E = 1; take_E = 0; pc_E = 20'hFFFFC; target_E = 20'h00555;
    tick();
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== 20'h00000) begin n_fail++; $display("FAIL wrap_rpc: got r=%0b pc=%h want 1 00000", redirect, redirect_pc); end
    n_checks++; if (upd_if.upd_take !== 1'b0 || upd_if.upd_branch !== 1'b1 || upd_if.upd_jump !== 1'b0) begin n_fail++; $display("FAIL wrap_upd: got t=%0b b=%0b j=%0b want 0 1 0", upd_if.upd_take, upd_if.upd_branch, upd_if.upd_jump); end
    n_checks++; if (upd_if.upd_pc !== 20'hFFFFC) begin n_fail++; $display("FAIL wrap_upd_pc: got %h want FFFFC", upd_if.upd_pc); end
    branch_E = 0;
    tick();
  endtask

  task automatic test_jump_target();
    do_reset();
    put_pred(1, 20'h00300);
    branch_E = 1; jump_E = 1; take_E = 0; pc_E = 20'h00010; target_E = 20'h00304;
    tick();
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== 20'h00304) begin n_fail++; $display("FAIL jump_rpc: got r=%0b pc=%h want 1 00304", redirect, redirect_pc); end
    n_checks++; if (upd_if.upd_jump !== 1'b1 || upd_if.upd_take !== 1'b1 || upd_if.upd_branch !== 1'b0) begin n_fail++; $display("FAIL jump_upd: got j=%0b t=%0b b=%0b want 1 1 0", upd_if.upd_jump, upd_if.upd_take, upd_if.upd_branch); end
    branch_E = 0; jump_E = 0;
    tick();
  endtask

  task automatic test_stall_flush();
    do_reset();
    put_pred(1, 20'h00100);
    branch_E = 1; take_E = 1; target_E = 20'h00100; pc_E = 20'h00020; stall_E = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (upd_if.upd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_upd[%0d]: got %0b want 0", i, upd_if.upd_valid); end
    end
    stall_E = 0;
    tick();
    n_checks++; if (upd_if.upd_valid !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL stall_release: got v=%0b r=%0b want 1 0", upd_if.upd_valid, redirect); end
    tick();
    n_checks++; if (upd_if.upd_valid !== 1'b0 || cnt_resolved !== 4'd1) begin n_fail++; $display("FAIL stall_single: got v=%0b cnt=%0d want 0 1", upd_if.upd_valid, cnt_resolved); end
    branch_E = 0;
    do_reset();
    put_pred(0, 20'h00000);
    fetch_valid_F = 1; pred_taken_F = 1; pred_target_F = 20'h00100;
    branch_E = 1; take_E = 1; target_E = 20'h00200; pc_E = 20'h00040;
    tick();
    fetch_valid_F = 0; branch_E = 0; stall_D = 1; stall_E = 1;
    n_checks++; if (flush_FD !== 1'b1) begin n_fail++; $display("FAIL flush_stall_setup: got %0b want 1", flush_FD); end
    tick();
    stall_D = 0; stall_E = 0;
    tick();
    branch_E = 1; take_E = 1; target_E = 20'h00100;
    tick();
    n_checks++; if (upd_if.upd_valid !== 1'b0 || cnt_resolved !== 4'd1) begin n_fail++; $display("FAIL flush_over_stall_D: got v=%0b cnt=%0d want 0 1", upd_if.upd_valid, cnt_resolved); end
    branch_E = 0;
  endtask

  task automatic test_reset_in_recover();
    do_reset();
    put_pred(0, 20'h00000);
    branch_E = 1; take_E = 1; target_E = 20'h00200; pc_E = 20'h00040;
    tick();
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL rst_rec_setup: got %0b want 1", redirect); end
    rst = 1;
    tick();
    rst = 0; branch_E = 0;
    n_checks++; if (redirect !== 1'b0 || flush_FD !== 1'b0 || redirect_pc !== '0) begin n_fail++; $display("FAIL rst_rec_outputs: got r=%0b f=%0b pc=%h want 0 0 0", redirect, flush_FD, redirect_pc); end
    n_checks++; if (upd_if.upd_valid !== 1'b0 || upd_if.upd_pc !== '0 || upd_if.upd_take !== 1'b0) begin n_fail++; $display("FAIL rst_rec_upd: got v=%0b pc=%h t=%0b want 0 0 0", upd_if.upd_valid, upd_if.upd_pc, upd_if.upd_take); end
    n_checks++; if (cnt_resolved !== '0 || cnt_mispredict !== '0) begin n_fail++; $display("FAIL rst_rec_counters: got %0d/%0d want 0/0", cnt_resolved, cnt_mispredict); end
    tick();
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rst_rec_idle: got %0b want 0", redirect); end
  endtask

  task automatic test_saturation();
    do_reset();
    fetch_valid_F = 1; pred_taken_F = 1; pred_target_F = 20'h00100;
    branch_E = 1; take_E = 1; target_E = 20'h00100; pc_E = 20'h00080;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (cnt_resolved !== 4'd5) begin n_fail++; $display("FAIL sat_partial: got %0d want 5", cnt_resolved); end
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if (cnt_resolved !== 4'd15 || cnt_mispredict !== 4'd0) begin n_fail++; $display("FAIL sat_final: got %0d/%0d want 15/0", cnt_resolved, cnt_mispredict); end
    n_checks++; if (upd_if.upd_valid !== 1'b1) begin n_fail++; $display("FAIL sat_back_to_back: got %0b want 1", upd_if.upd_valid); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [PC_W-1:0] pool [4];
    pool[0] = 20'h00100; pool[1] = 20'h00200; pool[2] = 20'hFFFFC; pool[3] = 20'h00040;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 79) == 0);
      fetch_valid_F = ($urandom_range(0, 3) != 0);
      pred_taken_F  = $urandom_range(0, 1);
      pred_target_F = pool[$urandom_range(0, 1)];
      stall_D       = ($urandom_range(0, 4) == 0);
      stall_E       = ($urandom_range(0, 4) == 0);
      branch_E      = $urandom_range(0, 1);
      jump_E        = ($urandom_range(0, 3) == 0);
      take_E        = $urandom_range(0, 1);
      pc_E          = ($urandom_range(0, 7) == 0) ? pool[2] : PC_W'($urandom);
      target_E      = ($urandom_range(0, 7) == 0) ? PC_W'($urandom) : pool[$urandom_range(0, 1)];
      tick();
      n_checks++; if (redirect !== m_recover || flush_FD !== m_recover) begin n_fail++; $display("FAIL rnd_redirect@%0d: got r=%0b f=%0b want %0b", i, redirect, flush_FD, m_recover); end
      if (m_recover) begin
        n_checks++; if (redirect_pc !== m_rpc) begin n_fail++; $display("FAIL rnd_rpc@%0d: got %h want %h", i, redirect_pc, m_rpc); end
      end
      n_checks++; if (upd_if.upd_valid !== m_uv) begin n_fail++; $display("FAIL rnd_upd_valid@%0d: got %0b want %0b", i, upd_if.upd_valid, m_uv); end
      if (m_uv) begin
        n_checks++;
        if (upd_if.upd_pc !== m_upc || upd_if.upd_take !== m_ut || upd_if.upd_branch !== m_ub || upd_if.upd_jump !== m_uj) begin
          n_fail++;
          $display("FAIL rnd_upd_fields@%0d: got pc=%h t=%0b b=%0b j=%0b want pc=%h t=%0b b=%0b j=%0b", i,
                   upd_if.upd_pc, upd_if.upd_take, upd_if.upd_branch, upd_if.upd_jump, m_upc, m_ut, m_ub, m_uj);
        end
      end
      n_checks++; if (int'(cnt_resolved) != m_cres || int'(cnt_mispredict) != m_cmis) begin n_fail++; $display("FAIL rnd_counters@%0d: got %0d/%0d want %0d/%0d", i, cnt_resolved, cnt_mispredict, m_cres, m_cmis); end
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_direction_mispredict();
    test_wrap_not_taken();
    test_jump_target();
    test_stall_flush();
    test_reset_in_recover();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolution unit; the producer side of the prediction-table update interface.
- Carries each fetched instruction's prediction (taken bit, predicted target) down F->D->E alongside the pipeline.
- In E, compares the prediction against the actual outcome and issues a registered redirect and front-end flush on mispredict.
- Emits a one-cycle update strobe to the pattern-history / target table, and keeps resolution and mispredict statistics counters.

Parameters:
PC_W, 20, PC / target width in bits
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
fetch_valid_F  in  1  F holds a real instruction
pred_taken_F  in  1  predicted taken (predictor state bit 1)
pred_target_F  in  PC_W  predicted target
stall_D  in  1  hold F->D register
stall_E  in  1  hold D->E register; no resolution this cycle
branch_E  in  1  E instruction is a conditional branch
jump_E  in  1  E instruction is an unconditional jump
take_E  in  1  branch condition result
pc_E  in  PC_W  PC of E instruction
target_E  in  PC_W  computed branch/jump target
redirect  out  1  fetch must load redirect_pc
redirect_pc  out  PC_W  correct next PC
flush_FD  out  1  squash F and D contents
upd_valid  out  1  predictor update strobe
upd_pc  out  PC_W  PC being updated
upd_take  out  1  actual direction (1 for jump)
upd_branch  out  1  update is a conditional branch
upd_jump  out  1  update is a jump
cnt_resolved  out  CNT_W  resolved branches+jumps
cnt_mispredict  out  CNT_W  mispredictions

Behaviour:
- Reset: all outputs 0; pD/pE valid 0; FSM in IDLE; counters 0. rst dominates every other input, including in the middle of a redirect.
- Prediction pipeline registers: pD = {valid, taken, target}; pE likewise.
- pD update:
  - If !stall_D: pD <= {fetch_valid_F, pred_taken_F, pred_target_F}.
  - If stall_D: pD holds.
- pE update:
  - If !stall_E: pE <= pD when !stall_D; otherwise pE <= bubble (valid=0).
  - If stall_E: pE holds.
- Flush: when flush_FD=1, pD.valid and pE.valid are cleared at the next edge. Flush wins over both stalls.
- Resolve condition: res = pE.valid & (branch_E | jump_E) & !stall_E & (state==IDLE).
- Actual direction: act_taken = jump_E | take_E.
- Actual next PC: act_next = act_taken ? target_E : pc_E + 4. The sum is modulo 2^PC_W, so the top PC wraps to low addresses.
- Mispredict: mis = res & ((act_taken != pE.taken) | (act_taken & target_E != pE.target)).
- FSM:
  - IDLE: if mis, go to RECOVER; otherwise stay.
  - RECOVER (exactly 1 cycle): redirect=1, flush_FD=1, redirect_pc = registered act_next. Any E instruction in this cycle is wrong-path and is not resolved or counted. Always returns to IDLE.
- Latency: redirect asserts one cycle after the resolving cycle. Update outputs also assert one cycle after resolution, are registered, and last one cycle. Back-to-back resolutions produce back-to-back upd_valid.
- Update fields: upd_valid=res, upd_pc=pc_E, upd_take=act_taken, upd_branch=branch_E & !jump_E, upd_jump=jump_E. If branch_E and jump_E are both 1, the instruction is treated as a jump.
- Counters:
  - cnt_resolved increments on res.
  - cnt_mispredict increments on mis.
  - Both saturate at all-ones with no wrap.
- An E instruction that is not valid, or not a branch/jump, never updates, counts or redirects, whatever the values of take_E and target_E.

Decomposition:
- Shared package (riscv_bp_pkg):
  - PC_W and CNT_W defaults.
  - FSM state encoding IDLE/RECOVER.
  - PC increment constant 4.
  - Predictor-state encoding, with bit 1 = taken.
- One natural sub-module: bp_pred_pipe. It holds the pD/pE registers with the stall/flush rules, so it can be reused for other per-instruction sideband data.

Test Plan:
- Correct taken prediction: pred_taken_F=1, target 0x00100; branch at E with take_E=1, target_E=0x00100 -> upd_valid=1, upd_take=1 one cycle later; redirect stays 0; cnt_resolved=1, cnt_mispredict=0.
- Direction mispredict: pred_taken=0; E branch pc_E=0x00040, take_E=1, target_E=0x00200 -> next cycle redirect=1, redirect_pc=0x00200, flush_FD=1; cnt_mispredict=1; a branch in E during RECOVER is not counted.
- Not-taken mispredict with wrap: pred_taken=1; pc_E=0xFFFFC, take_E=0 -> redirect_pc=0x00000, upd_take=0, upd_branch=1.
- Target mispredict on jump: pred_taken=1, pred_target=0x00300; jump_E=1, target_E=0x00304 -> redirect to 0x00304, upd_jump=1, upd_take=1.
- Stall/flush interplay: stall_E=1 for 3 cycles with a branch in E -> no upd_valid while stalled; exactly one update after release. Also, flush_FD asserted together with stall_D -> pD.valid=0.
- Reset mid-RECOVER and saturation: assert rst during RECOVER -> next cycle all outputs 0 and FSM in IDLE. With CNT_W=4, 17 resolutions -> cnt_resolved=15.
